// File: rtl/max_tree_pkg.sv
// max_tree_calc shared constants and helpers.
// Holds the max* correction LUT, clog2 and the saturation helpers.
package max_tree_pkg;

  localparam int WW      = 33;

  localparam int CORR_T0 = 2;
  localparam int CORR_T1 = 4;
  localparam int CORR_T2 = 8;

  localparam int CORR_V0 = 3;
  localparam int CORR_V1 = 2;
  localparam int CORR_V2 = 1;
  localparam int CORR_V3 = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic signed [WW-1:0] sat_hi(input int w);
    return (33'sd1 <<< (w - 1)) - 33'sd1;
  endfunction

  function automatic logic signed [WW-1:0] sat_lo(input int w);
    return -(33'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [WW-1:0] sat_clip(
    input logic signed [WW-1:0] v,
    input int                   w
  );
    if (v > sat_hi(w)) return sat_hi(w);
    if (v < sat_lo(w)) return sat_lo(w);
    return v;
  endfunction

  function automatic logic sat_hit(
    input logic signed [WW-1:0] v,
    input int                   w
  );
    return (v > sat_hi(w)) || (v < sat_lo(w));
  endfunction

  function automatic logic signed [WW-1:0] corr_lut(
    input logic signed [WW-1:0] d
  );
    if (d < CORR_T0) return 33'(CORR_V0);
    if (d < CORR_T1) return 33'(CORR_V1);
    if (d < CORR_T2) return 33'(CORR_V2);
    return 33'(CORR_V3);
  endfunction

endpackage

// File: rtl/max_tree_node.sv
// One compare node of the max tree: larger value wins, ties to x.
// With MAX_TREE_CALC_MAXSTAR_EN the result gets the max* correction.
module max_tree_node
  import max_tree_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int IW     = 2
) (
  input  logic signed [DWIDTH-1:0] x_val,
  input  logic        [IW-1:0]     x_idx,
  input  logic signed [DWIDTH-1:0] y_val,
  input  logic        [IW-1:0]     y_idx,
  output logic signed [DWIDTH-1:0] o_val,
  output logic        [IW-1:0]     o_idx,
  output logic                     o_sat
);

  logic                     y_win;
  logic signed [DWIDTH-1:0] mx;

  // select the larger operand; x holds the lower pair indices
  always_comb begin
    y_win = (y_val > x_val);
    mx    = y_win ? y_val : x_val;
    o_idx = y_win ? y_idx : x_idx;
  end

`ifdef MAX_TREE_CALC_MAXSTAR_EN
  logic signed [WW-1:0] diff;
  logic signed [WW-1:0] sum;

  // add the LUT correction and clamp at the positive limit
  always_comb begin
    diff  = y_win ? (33'(y_val) - 33'(x_val))
                  : (33'(x_val) - 33'(y_val));
    sum   = 33'(mx) + corr_lut(diff);
    o_val = DWIDTH'(sat_clip(sum, DWIDTH));
    o_sat = sat_hit(sum, DWIDTH);
  end
`else
  // plain max, never saturates
  always_comb begin
    o_val = mx;
    o_sat = 1'b0;
  end
`endif

endmodule

// File: rtl/max_tree_calc.sv
// Pipelined signed max (or max*) over NUM_PAIRS saturated sums.
// Optional max* correction: define MAX_TREE_CALC_MAXSTAR_EN.
module max_tree_calc
  import max_tree_pkg::*;
#(
  parameter int                   DWIDTH    = 16,
  parameter int                   NUM_PAIRS = 4,
  parameter logic [NUM_PAIRS-1:0] OPP_MASK  = '0
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [NUM_PAIRS*DWIDTH-1:0]         i_arg_a,
  input  logic [NUM_PAIRS*DWIDTH-1:0]         i_arg_b,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DWIDTH-1:0]                   o_max,
  output logic [clog2(NUM_PAIRS)-1:0]         o_max_idx,
  output logic                                o_sat,
  input  logic                                i_sat_clr
);

  localparam int L  = clog2(NUM_PAIRS);
  localparam int IW = L;
  localparam int NN = 2 * NUM_PAIRS - 1;
  localparam int NI = NUM_PAIRS - 1;

  logic signed [DWIDTH-1:0] val_q [NN];
  logic signed [DWIDTH-1:0] val_d [NN];
  logic        [IW-1:0]     idx_q [NN];
  logic        [IW-1:0]     idx_d [NN];
  logic        [L:0]        vld_q;
  logic        [L:0]        vld_d;
  logic                     sat_q;
  logic                     sat_d;

  logic signed [WW-1:0]     ws    [NUM_PAIRS];
  logic signed [DWIDTH-1:0] r_val [NUM_PAIRS];
  logic                     r_sat [NUM_PAIRS];

  logic signed [DWIDTH-1:0] nval  [NI];
  logic        [IW-1:0]     nidx  [NI];
  logic                     nsat  [NI];
  logic                     nlive [NI];

  logic adv;
  logic sat_s0;
  logic sat_nd;

  assign adv       = !vld_q[L] || m_ready;
  assign s_ready   = adv;
  assign m_valid   = vld_q[L];
  assign o_max     = val_q[0];
  assign o_max_idx = idx_q[0];
  assign o_sat     = sat_q;

  // stage 0: per-pair add/sub at full width, then saturate
  always_comb begin
    for (int i = 0; i < NUM_PAIRS; i++) begin
      if (OPP_MASK[i]) begin
        ws[i] = 33'($signed(i_arg_a[i*DWIDTH +: DWIDTH]))
              - 33'($signed(i_arg_b[i*DWIDTH +: DWIDTH]));
      end else begin
        ws[i] = 33'($signed(i_arg_a[i*DWIDTH +: DWIDTH]))
              + 33'($signed(i_arg_b[i*DWIDTH +: DWIDTH]));
      end
      r_val[i] = DWIDTH'(sat_clip(ws[i], DWIDTH));
      r_sat[i] = sat_hit(ws[i], DWIDTH);
    end
  end

  // heap-ordered tree: node k reads children 2k+1 and 2k+2
  for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
    for (genvar j = 0; j < (NUM_PAIRS >> lv); j++) begin : g_node
      localparam int K = (NUM_PAIRS >> lv) - 1 + j;
      max_tree_node #(
        .DWIDTH (DWIDTH),
        .IW     (IW)
      ) u_node (
        .x_val (val_q[2*K+1]),
        .x_idx (idx_q[2*K+1]),
        .y_val (val_q[2*K+2]),
        .y_idx (idx_q[2*K+2]),
        .o_val (nval[K]),
        .o_idx (nidx[K]),
        .o_sat (nsat[K])
      );
      assign nlive[K] = vld_q[lv-1];
    end
  end

  // next state: whole pipeline moves together when adv
  always_comb begin
    val_d  = val_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    sat_s0 = 1'b0;
    sat_nd = 1'b0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      sat_s0 = sat_s0 | r_sat[i];
    end
    for (int k = 0; k < NI; k++) begin
      sat_nd = sat_nd | (nsat[k] & nlive[k]);
    end
    if (adv) begin
      vld_d[0] = s_valid;
      for (int l = 1; l <= L; l++) begin
        vld_d[l] = vld_q[l-1];
      end
      for (int i = 0; i < NUM_PAIRS; i++) begin
        val_d[NI+i] = r_val[i];
        idx_d[NI+i] = IW'(i);
      end
      for (int k = 0; k < NI; k++) begin
        val_d[k] = nval[k];
        idx_d[k] = nidx[k];
      end
    end
    sat_d = (sat_q && !i_sat_clr)
         || (adv && s_valid && sat_s0)
         || (adv && sat_nd);
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int n = 0; n < NN; n++) begin
        val_q[n] <= '0;
        idx_q[n] <= '0;
      end
      vld_q <= '0;
      sat_q <= 1'b0;
    end else begin
      val_q <= val_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_max_tree_calc.sv
// Directed bench for max_tree_calc (default params, plus a subtract
// instance); expectations follow MAX_TREE_CALC_MAXSTAR_EN if defined.
module tb_max_tree_calc;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    int          emax;
    int          eidx;
    int          esat;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [63:0] i_arg_a, i_arg_b;
  logic [15:0] o_max;
  logic [1:0]  o_max_idx;
  logic        o_sat, i_sat_clr;

  logic        sb_s_valid, sb_s_ready, sb_m_valid, sb_m_ready;
  logic [63:0] sb_a, sb_b;
  logic [15:0] sb_max;
  logic [1:0]  sb_idx;
  logic        sb_sat, sb_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  max_tree_calc u_dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .i_arg_a   (i_arg_a),
    .i_arg_b   (i_arg_b),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .o_max     (o_max),
    .o_max_idx (o_max_idx),
    .o_sat     (o_sat),
    .i_sat_clr (i_sat_clr)
  );

  max_tree_calc #(.OPP_MASK(4'b1111)) u_sub (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_valid   (sb_s_valid),
    .s_ready   (sb_s_ready),
    .i_arg_a   (sb_a),
    .i_arg_b   (sb_b),
    .m_valid   (sb_m_valid),
    .m_ready   (sb_m_ready),
    .o_max     (sb_max),
    .o_max_idx (sb_idx),
    .o_sat     (sb_sat),
    .i_sat_clr (sb_clr)
  );

  function automatic logic [63:0] pk(input int x0, x1, x2, x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_one(input vec_t v);
    int lat;
    tick();
    i_sat_clr = 1'b1;
    tick();
    i_sat_clr = 1'b0;
    i_arg_a   = v.a;
    i_arg_b   = v.b;
    s_valid   = 1'b1;
    m_ready   = 1'b1;
    lat       = 0;
    do begin
      tick();
      lat++;
      s_valid = 1'b0;
    end while (!m_valid && lat < 12);
    chk({v.name, "_lat"}, lat, 3);
    chk({v.name, "_max"}, int'($signed(o_max)), v.emax);
    chk({v.name, "_idx"}, int'(o_max_idx), v.eidx);
    chk({v.name, "_sat"}, int'(o_sat), v.esat);
    tick();
    chk({v.name, "_bubble"}, int'(m_valid), 0);
  endtask

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int sent, recv, cyc, n_stall, extra, cnt;
    logic        pstall;
    logic [15:0] hmax;
    logic [1:0]  hidx;

`ifdef MAX_TREE_CALC_MAXSTAR_EN
    tbl.push_back('{"ms_10_9", pk(10, 9, 0, 0), pk(0, 0, 0, 0), 13, 0, 0});
    tbl.push_back('{"ms_sat", pk(32766, 32766, 0, 0), pk(0, 0, 0, 0),
                    32767, 0, 1});
    tbl.push_back('{"ms_neg_eq", pk(-5, -5, -5, -5), pk(0, 0, 0, 0), 1, 0, 0});
    tbl.push_back('{"ms_eq5", pk(4, 4, 4, 4), pk(1, 1, 1, 1), 11, 0, 0});
    tbl.push_back('{"ms_basic", pk(10, 20, -5, 7), pk(1, 1, 1, 1), 21, 1, 0});
`else
    tbl.push_back('{"basic", pk(10, 20, -5, 7), pk(1, 1, 1, 1), 21, 1, 0});
    tbl.push_back('{"eq5", pk(4, 4, 4, 4), pk(1, 1, 1, 1), 5, 0, 0});
    tbl.push_back('{"neg_tie", pk(-10, -3, -8, -3), pk(0, 0, 0, 0), -3, 1, 0});
    tbl.push_back('{"top_idx", pk(0, 0, 0, 100), pk(0, 0, 0, -1), 99, 3, 0});
    tbl.push_back('{"neg_sat", pk(-32768, -32768, -32768, -32768),
                    pk(-1, -1, -1, -1), -32768, 0, 1});
    tbl.push_back('{"pos_sat2", pk(0, 0, 32767, 32000), pk(0, 0, 5, 700),
                    32767, 2, 1});
    tbl.push_back('{"pos_sat0", pk(32767, 0, 0, 0), pk(1, 0, 0, 0),
                    32767, 0, 1});
    tbl.push_back('{"mixed", pk(-1, 0, -2, 1), pk(0, 0, 0, -1), 0, 1, 0});
`endif

    aresetn    = 1'b0;
    s_valid    = 1'b0;
    m_ready    = 1'b1;
    i_arg_a    = '0;
    i_arg_b    = '0;
    i_sat_clr  = 1'b0;
    sb_s_valid = 1'b0;
    sb_m_ready = 1'b1;
    sb_a       = '0;
    sb_b       = '0;
    sb_clr     = 1'b0;

    repeat (3) tick();
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_o_max", int'(o_max), 0);
    chk("rst_o_idx", int'(o_max_idx), 0);
    chk("rst_o_sat", int'(o_sat), 0);
    aresetn = 1'b1;
    tick();
    chk("rst_s_ready", int'(s_ready), 1);

    foreach (tbl[t]) apply_one(tbl[t]);

    // sticky flag: set, clear, then clear and set together
    apply_one('{"satseq", pk(32767, 0, 0, 0), pk(1, 0, 0, 0), 32767, 0, 1});
    i_sat_clr = 1'b1;
    tick();
    i_sat_clr = 1'b0;
    tick();
    chk("sat_cleared", int'(o_sat), 0);
    i_arg_a   = pk(32767, 0, 0, 0);
    i_arg_b   = pk(1, 0, 0, 0);
    s_valid   = 1'b1;
    i_sat_clr = 1'b1;
    tick();
    s_valid   = 1'b0;
    i_sat_clr = 1'b0;
    chk("sat_set_wins", int'(o_sat), 1);
    repeat (4) tick();

    // subtract instance: r = {-3,-1,-2,-4}
    sb_a       = pk(0, 0, 0, 0);
    sb_b       = pk(3, 1, 2, 4);
    sb_s_valid = 1'b1;
    cnt        = 0;
    do begin
      tick();
      cnt++;
      sb_s_valid = 1'b0;
    end while (!sb_m_valid && cnt < 12);
    chk("sub_lat", cnt, 3);
`ifdef MAX_TREE_CALC_MAXSTAR_EN
    chk("sub_max", int'($signed(sb_max)), 4);
`else
    chk("sub_max", int'($signed(sb_max)), -1);
`endif
    chk("sub_idx", int'(sb_idx), 1);

    // stream of 8 with a 4-cycle downstream stall
    sent    = 0;
    recv    = 0;
    cyc     = 0;
    n_stall = 0;
    pstall  = 1'b0;
    hmax    = '0;
    hidx    = '0;
    tick();
    while (recv < 8 && cyc < 80) begin
      s_valid = (sent < 8);
      i_arg_a = pk((sent % 4 == 0) ? 100 + sent : 0,
                   (sent % 4 == 1) ? 100 + sent : 1,
                   (sent % 4 == 2) ? 100 + sent : 2,
                   (sent % 4 == 3) ? 100 + sent : 3);
      i_arg_b = '0;
      m_ready = !(cyc >= 6 && cyc < 10);
      #1;
      if (m_valid && m_ready) begin
        chk("stream_max", int'(o_max), 100 + recv);
        chk("stream_idx", int'(o_max_idx), recv % 4);
        recv++;
      end
      if (m_valid && !m_ready) begin
        n_stall++;
        chk("stall_s_ready", int'(s_ready), 0);
        if (pstall) begin
          chk("stall_max_hold", int'(o_max), int'(hmax));
          chk("stall_idx_hold", int'(o_max_idx), int'(hidx));
        end
        hmax   = o_max;
        hidx   = o_max_idx;
        pstall = 1'b1;
      end else begin
        pstall = 1'b0;
      end
      if (s_valid && s_ready) sent++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("stream_recv", recv, 8);
    chk("stream_sent", sent, 8);
    chk("stream_stalls", n_stall, 4);
    extra = 0;
    repeat (6) begin
      tick();
      if (m_valid) extra++;
    end
    chk("stream_extra", extra, 0);

    // reset with two vectors in flight
    i_arg_a = pk(50, 0, 0, 0);
    i_arg_b = '0;
    s_valid = 1'b1;
    tick();
    i_arg_a = pk(0, 60, 0, 0);
    tick();
    s_valid = 1'b0;
    aresetn = 1'b0;
    tick();
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_o_max", int'(o_max), 0);
    aresetn = 1'b1;
    extra   = 0;
    repeat (6) begin
      tick();
      if (m_valid) extra++;
    end
    chk("mid_rst_stale", extra, 0);
    chk("mid_rst_s_ready", int'(s_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
